// File: rtl/mac_layer_sequencer_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
package mac_layer_sequencer_pkg;

   localparam int ACC_W     = 22;
   localparam int ACC_FRAC  = 12;
   localparam int TAG_IDX_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } seq_state_t;

   typedef struct packed {
      logic                 first;
      logic                 last;
      logic [TAG_IDX_W-1:0] idx;
   } seq_tag_t;

endpackage

// File: rtl/mac_layer_sequencer_tag_delay.sv
// Aligns issue-side tags with the product arriving at the accumulator input.
module seq_tag_delay
   import mac_layer_sequencer_pkg::*;
#(
   parameter int PIPE_LAT = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  seq_tag_t i_tag,
   output seq_tag_t o_tag
);

   seq_tag_t r_pipe [PIPE_LAT];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < PIPE_LAT; k++) r_pipe[k] <= '0;
      end else begin
         r_pipe[0] <= i_tag;
         for (int k = 1; k < PIPE_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign o_tag = r_pipe[PIPE_LAT-1];

endmodule

// File: rtl/mac_layer_sequencer.sv
// Layer sequencer: walks neuron/input indices, issues memory addresses and accumulator strobes.
// Optional ARGMAX_EN adds a running arg-max of the neuron results (class_idx/class_valid).
//
//  state | meaning
//  IDLE  | waiting for start; addresses hold their last value
//  ISSUE | one input/weight address per cycle, neurons back to back
//  DRAIN | pipeline emptying until the last neuron result is presented
module mac_layer_sequencer
   import mac_layer_sequencer_pkg::*;
#(
   parameter int N_INPUTS  = 784,
   parameter int N_NEURONS = 10,
   parameter int PIPE_LAT  = 2,
   parameter int IN_AW     = 10,
   parameter int NEU_AW    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [IN_AW-1:0]         in_addr,
   output logic [IN_AW+NEU_AW-1:0]  w_addr,
   output logic [NEU_AW-1:0]        bias_addr,
   output logic                     acc_sel,
   output logic                     acc_en,
   input  logic [ACC_W-1:0]         acc_result,
   output logic                     res_valid,
   output logic [ACC_W-1:0]         res_data,
   output logic [NEU_AW-1:0]        res_idx
`ifdef ARGMAX_EN
   ,
   output logic [NEU_AW-1:0]        class_idx,
   output logic                     class_valid
`endif
);

   localparam logic [IN_AW-1:0]     LAST_IN  = IN_AW'(N_INPUTS - 1);
   localparam logic [NEU_AW-1:0]    LAST_NEU = NEU_AW'(N_NEURONS - 1);
   localparam logic [TAG_IDX_W-1:0] LAST_TAG = TAG_IDX_W'(N_NEURONS - 1);

   seq_state_t             r_state;
   logic [IN_AW-1:0]       r_in_idx;
   logic [NEU_AW-1:0]      r_neu_idx;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_res_valid;
   logic [TAG_IDX_W-1:0]   r_res_tag_idx;
   seq_tag_t               w_tag;
   seq_tag_t               w_dly;

   always_comb begin
      w_tag       = '0;
      w_tag.first = (r_state == ISSUE) && (r_in_idx == '0);
      w_tag.last  = (r_state == ISSUE) && (r_in_idx == LAST_IN);
      w_tag.idx   = TAG_IDX_W'(r_neu_idx);
   end

   seq_tag_delay #(.PIPE_LAT(PIPE_LAT)) u_tag_delay (
      .clk   (clk),
      .reset (reset),
      .i_tag (w_tag),
      .o_tag (w_dly)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_in_idx      <= '0;
         r_neu_idx     <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_tag_idx <= '0;
      end else begin
         r_done      <= 1'b0;
         r_res_valid <= w_dly.last;
         if (w_dly.last) r_res_tag_idx <= w_dly.idx;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state   <= ISSUE;
                  r_busy    <= 1'b1;
                  r_in_idx  <= '0;
                  r_neu_idx <= '0;
               end
            end
            ISSUE: begin
               if (r_in_idx == LAST_IN) begin
                  if (r_neu_idx == LAST_NEU) begin
                     r_state <= DRAIN;
                  end else begin
                     r_in_idx  <= '0;
                     r_neu_idx <= r_neu_idx + NEU_AW'(1);
                  end
               end else begin
                  r_in_idx <= r_in_idx + IN_AW'(1);
               end
            end
            DRAIN: begin
               // with a long pipe an earlier neuron can still complete here
               if (r_res_valid && (r_res_tag_idx == LAST_TAG)) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign in_addr   = r_in_idx;
   assign w_addr    = {r_neu_idx, r_in_idx};
   assign bias_addr = r_neu_idx;
   assign acc_sel   = w_dly.first;
   assign acc_en    = w_dly.last;
   assign res_valid = r_res_valid;
   assign res_idx   = r_res_tag_idx[NEU_AW-1:0];
   assign res_data  = r_res_valid ? acc_result : '0;

`ifdef ARGMAX_EN
   logic                    r_have;
   logic signed [ACC_W-1:0] r_max;
   logic [NEU_AW-1:0]       r_best;
   logic                    r_class_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_have        <= 1'b0;
         r_max         <= '0;
         r_best        <= '0;
         r_class_valid <= 1'b0;
      end else begin
         r_class_valid <= (r_state == DRAIN) && r_res_valid && (r_res_tag_idx == LAST_TAG);
         if ((r_state == IDLE) && start) begin
            r_have <= 1'b0;
            r_best <= '0;
         end else if (r_res_valid && (!r_have || ($signed(acc_result) > r_max))) begin
            // strict compare keeps the lower index on ties
            r_have <= 1'b1;
            r_max  <= $signed(acc_result);
            r_best <= res_idx;
         end
      end
   end

   assign class_idx   = r_best;
   assign class_valid = r_class_valid;
`endif

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Bench for mac_layer_sequencer: two configurations driven together, checked against a timing model.
module tb_mac_layer_sequencer;

   localparam int IN_AW  = 4;
   localparam int NEU_AW = 4;
   localparam int NIa [2] = '{4, 2};
   localparam int NNa [2] = '{3, 1};
   localparam int PLa [2] = '{2, 1};

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   always #5 clk = ~clk;

   logic              busy [2];
   logic              done [2];
   logic [IN_AW-1:0]  in_addr [2];
   logic [7:0]        w_addr [2];
   logic [3:0]        bias_addr [2];
   logic              acc_sel [2];
   logic              acc_en [2];
   logic [21:0]       accr [2];
   logic              res_valid [2];
   logic [21:0]       res_data [2];
   logic [3:0]        res_idx [2];
`ifdef ARGMAX_EN
   logic [3:0]        class_idx [2];
   logic              class_valid [2];
`endif

   mac_layer_sequencer #(.N_INPUTS(4), .N_NEURONS(3), .PIPE_LAT(2), .IN_AW(IN_AW), .NEU_AW(NEU_AW)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
      .in_addr(in_addr[0]), .w_addr(w_addr[0]), .bias_addr(bias_addr[0]),
      .acc_sel(acc_sel[0]), .acc_en(acc_en[0]), .acc_result(accr[0]),
      .res_valid(res_valid[0]), .res_data(res_data[0]), .res_idx(res_idx[0])
`ifdef ARGMAX_EN
      , .class_idx(class_idx[0]), .class_valid(class_valid[0])
`endif
   );

   mac_layer_sequencer #(.N_INPUTS(2), .N_NEURONS(1), .PIPE_LAT(1), .IN_AW(IN_AW), .NEU_AW(NEU_AW)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
      .in_addr(in_addr[1]), .w_addr(w_addr[1]), .bias_addr(bias_addr[1]),
      .acc_sel(acc_sel[1]), .acc_en(acc_en[1]), .acc_result(accr[1]),
      .res_valid(res_valid[1]), .res_data(res_data[1]), .res_idx(res_idx[1])
`ifdef ARGMAX_EN
      , .class_idx(class_idx[1]), .class_valid(class_valid[1])
`endif
   );

   int n_chk = 0;
   int n_fail = 0;
   int n = 0;
   int n0 = 0;

   // model state: a pass is "act" with t = cycles since the accepted start
   int act [2], t [2], last_in [2], last_neu [2], best [2], have [2];
   longint maxv [2];
   bit mvalid = 0, post_rst = 0, use_dir = 0, rec = 0;
   logic [21:0] dir_vals [3] = '{22'h3FFFFB, 22'd300, 22'd300};

   int q_rv0[$], q_idx0[$], q_sel0[$], q_en0[$], q_done0[$], q_rv1[$], q_done1[$], q_cls0[$];
   logic [21:0] q_rd0[$];

   task automatic chk(input string nm, input int inst, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, inst, n, got, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic rb);
      int ni, nn, pl, tt, nt, j, a, b, rel;
      logic e_busy, e_done, e_sel, e_en, e_rv;
      int e_ridx;
      logic [21:0] v;
      logic [21:0] drv [2];
      logic ev_rv [2], ev_done [2], ev_sel [2], ev_en [2];
      int ev_idx [2];
      start = st;
      reset = rb;
      for (int i = 0; i < 2; i++) begin
         ni = NIa[i]; nn = NNa[i]; pl = PLa[i];
         tt = 2 + nn*ni + pl; nt = nn*ni;
         if (act[i] != 0 && t[i] >= 1 && t[i] <= nt) begin
            j = t[i] - 1;
            last_in[i] = j % ni;
            last_neu[i] = j / ni;
         end
         a = t[i] - 1 - pl;
         b = t[i] - 2 - pl;
         ev_done[i] = act[i] != 0 && t[i] == tt;
         ev_sel[i]  = act[i] != 0 && a >= 0 && a < nt && (a % ni) == 0;
         ev_en[i]   = act[i] != 0 && a >= 0 && a < nt && (a % ni) == ni - 1;
         ev_rv[i]   = act[i] != 0 && b >= 0 && b < nt && (b % ni) == ni - 1;
         ev_idx[i]  = ev_rv[i] ? b / ni : 0;
         v = 22'($urandom);
         if (ev_rv[i] && use_dir && i == 0) v = dir_vals[ev_idx[i]];
         drv[i] = v;
         accr[i] = v;
         if (ev_rv[i] && (have[i] == 0 || longint'($signed(v)) > maxv[i])) begin
            maxv[i] = longint'($signed(v));
            best[i] = ev_idx[i];
            have[i] = 1;
         end
      end
      #1;
      if (mvalid) begin
         rel = n - n0;
         for (int i = 0; i < 2; i++) begin
            ni = NIa[i]; nn = NNa[i]; pl = PLa[i];
            tt = 2 + nn*ni + pl;
            e_busy = act[i] != 0 && t[i] >= 1 && t[i] <= tt - 1;
            e_done = ev_done[i]; e_sel = ev_sel[i]; e_en = ev_en[i]; e_rv = ev_rv[i]; e_ridx = ev_idx[i];
            chk("busy", i, 64'(busy[i]), 64'(e_busy));
            chk("done", i, 64'(done[i]), 64'(e_done));
            chk("in_addr", i, 64'(in_addr[i]), 64'(last_in[i]));
            chk("w_addr", i, 64'(w_addr[i]), 64'(last_neu[i] * 16 + last_in[i]));
            chk("bias_addr", i, 64'(bias_addr[i]), 64'(last_neu[i]));
            chk("acc_sel", i, 64'(acc_sel[i]), 64'(e_sel));
            chk("acc_en", i, 64'(acc_en[i]), 64'(e_en));
            chk("res_valid", i, 64'(res_valid[i]), 64'(e_rv));
            if (e_rv) begin
               chk("res_data", i, 64'(res_data[i]), 64'(drv[i]));
               chk("res_idx", i, 64'(res_idx[i]), 64'(e_ridx));
            end
            if (post_rst) begin
               chk("rst_res_data", i, 64'(res_data[i]), 64'(0));
               chk("rst_res_idx", i, 64'(res_idx[i]), 64'(0));
            end
`ifdef ARGMAX_EN
            chk("class_valid", i, 64'(class_valid[i]), 64'(e_done));
            if (e_done) chk("class_idx", i, 64'(class_idx[i]), 64'(best[i]));
            if (post_rst) chk("rst_class_idx", i, 64'(class_idx[i]), 64'(0));
`endif
         end
         if (rec) begin
            if (res_valid[0]) begin q_rv0.push_back(rel); q_idx0.push_back(int'(res_idx[0])); q_rd0.push_back(res_data[0]); end
            if (acc_sel[0]) q_sel0.push_back(rel);
            if (acc_en[0]) q_en0.push_back(rel);
            if (done[0]) q_done0.push_back(rel);
            if (res_valid[1]) q_rv1.push_back(rel);
            if (done[1]) q_done1.push_back(rel);
            chk("sel_en_excl", 1, 64'(acc_sel[1] & acc_en[1]), 64'(0));
`ifdef ARGMAX_EN
            if (class_valid[0]) q_cls0.push_back(int'(class_idx[0]));
`endif
         end
      end
      @(posedge clk);
      #1;
      n++;
      for (int i = 0; i < 2; i++) begin
         tt = 2 + NNa[i]*NIa[i] + PLa[i];
         if (!rb) begin
            act[i] = 0; t[i] = 0; last_in[i] = 0; last_neu[i] = 0; have[i] = 0; best[i] = 0;
         end else if (st && (act[i] == 0 || t[i] == tt)) begin
            act[i] = 1; t[i] = 1; have[i] = 0; best[i] = 0;
         end else if (act[i] != 0) begin
            t[i]++;
            if (t[i] > tt) act[i] = 0;
         end
      end
      if (!rb) mvalid = 1;
      post_rst = !rb;
   endtask

   task automatic chk_q(input string nm, input int q[$], input int exp[], input int cnt);
      chk({nm, "_count"}, 0, 64'(q.size()), 64'(cnt));
      for (int k = 0; k < exp.size(); k++)
         chk(nm, 0, (k < q.size()) ? 64'(q[k]) : 64'hFFFF, 64'(exp[k]));
   endtask

   initial begin
      int e_rv0[], e_idx0[], e_sel0[], e_en0[], e_d0[], e_rv1[], e_d1[];
      logic [21:0] lit_rd [3];
      for (int i = 0; i < 2; i++) begin
         act[i] = 0; t[i] = 0; last_in[i] = 0; last_neu[i] = 0; best[i] = 0; have[i] = 0; maxv[i] = 0;
      end
      accr[0] = '0; accr[1] = '0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
      for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1);

      // directed pass with ignored restarts at 5 and 9, pinned result values
      n0 = n; rec = 1; use_dir = 1;
      for (int k = 0; k < 21; k++) cyc(k == 0 || k == 5 || k == 9, 1'b1);
      rec = 0; use_dir = 0;
      e_rv0 = '{7, 11, 15}; e_idx0 = '{0, 1, 2}; e_sel0 = '{3, 7, 11}; e_en0 = '{6, 10, 14}; e_d0 = '{16};
      chk_q("lit_rv0", q_rv0, e_rv0, 3);
      chk_q("lit_ridx0", q_idx0, e_idx0, 3);
      chk_q("lit_sel0", q_sel0, e_sel0, 3);
      chk_q("lit_en0", q_en0, e_en0, 3);
      chk_q("lit_done0", q_done0, e_d0, 1);
      lit_rd = '{22'h3FFFFB, 22'd300, 22'd300};
      for (int k = 0; k < 3; k++)
         chk("lit_res_data", 0, (k < q_rd0.size()) ? 64'(q_rd0[k]) : 64'hFFFFFFFF, 64'(lit_rd[k]));
      // second config: restarted by the pulse at 5 (already idle), so two passes
      e_rv1 = '{4, 9}; e_d1 = '{5, 10};
      chk_q("lit_rv1", q_rv1, e_rv1, 2);
      chk_q("lit_done1", q_done1, e_d1, 2);
`ifdef ARGMAX_EN
      chk("lit_class_cnt", 0, 64'(q_cls0.size()), 64'(1));
      if (q_cls0.size() > 0) chk("lit_class_idx", 0, 64'(q_cls0[0]), 64'(1));
`endif

      // mid-pass reset at 8, new start at 12
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1);
      n0 = n;
      for (int k = 0; k < 32; k++) cyc(k == 0 || k == 12, k != 8);

      // back-to-back passes: start on the cycle after done
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);
      for (int k = 0; k < 53; k++) cyc((k % 17) == 0, 1'b1);

      // random starts, rare resets
      for (int k = 0; k < 900; k++)
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 149) != 0);
      for (int k = 0; k < 25; k++) cyc(1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
